// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one registered 4-bit binary-to-BCD converter among N_REQ requesters
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   req, bin      per-requester level request and 4-bit operand (requester i uses bin[4i+3:4i])
//   conv_bin      registered operand driven to the shared converter
//   conv_bcd      converter result {tens, ones}, valid one cycle after conv_bin
//   ack           one-hot completion pulse to the served requester
//   resp_bcd      BCD result of the last completed conversion
//   resp_id       index of the last served requester
//   busy          high while a conversion is in flight
module bcd_conv_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] bin,
    output logic [3:0]         conv_bin,
    input  logic [7:0]         conv_bcd,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         resp_bcd,
    output logic [ID_W-1:0]    resp_id,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d, grant_id_q, grant_id_d, resp_id_q, resp_id_d;
    logic [3:0]       conv_bin_q, conv_bin_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [7:0]       resp_bcd_q, resp_bcd_d;
    logic [N_REQ-1:0] elig;
    logic [ID_W-1:0]  win_hi, win_lo, win;
    logic             hit_hi;
    logic [3:0]       win_bin;
    // Rotating priority: lowest eligible index at or above ptr, else lowest eligible index overall.
    // The requester acked this cycle is masked so its lingering req cannot win again.
    always_comb begin
        elig   = req & ~ack_q;
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                if (ID_W'(i) >= ptr_q) begin
                    win_hi = ID_W'(i);
                    hit_hi = 1'b1;
                end else begin
                    win_lo = ID_W'(i);
                end
            end
        end
        win     = hit_hi ? win_hi : win_lo;
        win_bin = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win == ID_W'(i)) win_bin = bin[4*i +: 4];
    end
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        conv_bin_d = conv_bin_q;
        ack_d      = '0;
        resp_bcd_d = resp_bcd_q;
        resp_id_d  = resp_id_q;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    grant_id_d = win;
                    conv_bin_d = win_bin;
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                resp_bcd_d = conv_bcd;
                resp_id_d  = grant_id_q;
                for (int i = 0; i < N_REQ; i++) ack_d[i] = (grant_id_q == ID_W'(i));
                ptr_d      = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            conv_bin_q <= '0;
            ack_q      <= '0;
            resp_bcd_q <= '0;
            resp_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            conv_bin_q <= conv_bin_d;
            ack_q      <= ack_d;
            resp_bcd_q <= resp_bcd_d;
            resp_id_q  <= resp_id_d;
        end
    end
    assign conv_bin = conv_bin_q;
    assign ack      = ack_q;
    assign resp_bcd = resp_bcd_q;
    assign resp_id  = resp_id_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed and randomized checks of bcd_conv_arbiter against a transaction-level model
module tb_bcd_conv_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] bin = '0;
    logic [3:0]  conv_bin;
    logic [7:0]  conv_bcd;
    logic [3:0]  ack;
    logic [7:0]  resp_bcd;
    logic [1:0]  resp_id;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    bcd_conv_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .bin(bin), .conv_bin(conv_bin),
        .conv_bcd(conv_bcd), .ack(ack), .resp_bcd(resp_bcd), .resp_id(resp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // shared converter: one register stage, {tens, ones}
    always @(posedge clk or negedge rst)
        if (!rst) conv_bcd <= 8'h00;
        else conv_bcd <= (conv_bin >= 4'd10) ? {4'd1, conv_bin - 4'd10} : {4'd0, conv_bin};

    // transaction-level model: each grant completes two edges after it is decided
    int         m_left;
    int         m_ptr;
    int         m_gid;
    logic [3:0] m_conv;
    logic [3:0] m_ack;
    logic [7:0] m_resp;
    logic [1:0] m_rid;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0; m_ptr = 0; m_gid = 0; m_conv = 0; m_ack = 0; m_resp = 0; m_rid = 0;
        end else if (m_left == 0) begin
            logic [3:0] elig;
            bit found;
            elig = req & ~m_ack;
            m_ack = '0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!found && elig[c]) begin
                    found = 1;
                    m_gid = c;
                end
            end
            if (found) begin
                m_conv = bin[4*m_gid +: 4];
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_left = 1;
        end else begin
            int v;
            v = int'(m_conv);
            m_ack = 4'b0001 << m_gid;
            m_resp = 8'((v / 10) * 16 + v % 10);
            m_rid = 2'(m_gid);
            m_ptr = (m_gid + 1) % 4;
            m_left = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({conv_bin, ack, resp_bcd, resp_id, busy} !== {m_conv, m_ack, m_resp, m_rid, m_left != 0}) begin
                miscompares++;
                $display("FAIL model t=%0t: conv_bin %h/%h ack %b/%b resp_bcd %h/%h resp_id %0d/%0d busy %b/%b (got/want)",
                         $time, conv_bin, m_conv, ack, m_ack, resp_bcd, m_resp, resp_id, m_rid, busy, m_left != 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (ack == 0 && waited < budget);
        if (ack == 0) begin
            miscompares++;
            $display("FAIL ack_timeout: got no ack within %0d cycles", budget);
        end
    endtask

    initial begin
        logic [7:0] exp_bcd [4] = '{8'h15, 8'h09, 8'h10, 8'h00};
        logic [3:0] prev_ack;
        int w;
        int acks_seen;
        // reset with random inputs
        req = 4'($urandom);
        bin = 16'($urandom);
        step();
        chk_en = 1'b1;
        step();
        chk("reset_outputs", {conv_bin, ack, resp_bcd, resp_id, busy}, 32'h0);
        req = '0;
        rst = 1'b1;
        acks_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (ack != 0 || busy) acks_seen++;
        end
        chk("idle_after_reset", acks_seen, 0);
        // single request
        req = 4'b0010;
        bin[7:4] = 4'd13;
        step();
        chk("single_conv_bin", conv_bin, 4'd13);
        chk("single_busy", busy, 1);
        step();
        step();
        chk("single_ack", ack, 4'b0010);
        chk("single_resp_bcd", resp_bcd, 8'h13);
        chk("single_resp_id", resp_id, 1);
        chk("model_single_resp", m_resp, 8'h13);
        req = '0;
        step();
        chk("single_ack_clears", ack, 0);
        // all four requesting from reset
        rst = 1'b0;
        req = 4'b1111;
        bin = {4'd0, 4'd10, 4'd9, 4'd15};
        step();
        step();
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ack(10, w);
            chk($sformatf("all4_spacing%0d", n), w, 3);
            chk($sformatf("all4_ack%0d", n), ack, 4'b0001 << n);
            chk($sformatf("all4_bcd%0d", n), resp_bcd, exp_bcd[n]);
            chk($sformatf("all4_id%0d", n), resp_id, n);
            req &= ~ack;
        end
        // fairness: after 2 is served, 3 beats 0, then 0 follows
        req = 4'b0100;
        bin[11:8] = 4'd5;
        wait_ack(10, w);
        chk("fair_ack2", ack, 4'b0100);
        req = 4'b1001;
        bin[15:12] = 4'd3;
        bin[3:0] = 4'd8;
        wait_ack(10, w);
        chk("fair_first3", ack, 4'b1000);
        chk("fair_bcd3", resp_bcd, 8'h03);
        chk("fair_wait3", w, 3);
        req = 4'b0001;
        wait_ack(10, w);
        chk("fair_then0", ack, 4'b0001);
        chk("fair_bcd0", resp_bcd, 8'h08);
        req = '0;
        // ack masking: 1 lingers one cycle past its ack while 3 requests
        step();
        req = 4'b0010;
        bin[7:4] = 4'd2;
        wait_ack(10, w);
        chk("mask_ack1", ack, 4'b0010);
        req = 4'b1010;
        bin[15:12] = 4'd4;
        step();
        req = 4'b1000;
        wait_ack(10, w);
        chk("mask_next3", ack, 4'b1000);
        chk("mask_id3", resp_id, 3);
        chk("mask_bcd", resp_bcd, 8'h04);
        req = '0;
        step();
        // reset during ISSUE discards the conversion
        req = 4'b0001;
        bin[3:0] = 4'd7;
        step();
        chk("midop_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("midop_async_clear", {busy, conv_bin}, 0);
        acks_seen = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (ack != 0) acks_seen++;
        end
        chk("midop_no_ack", acks_seen, 0);
        rst = 1'b1;
        wait_ack(10, w);
        chk("midop_latency", w, 3);
        chk("midop_ack", ack, 4'b0001);
        chk("midop_bcd", resp_bcd, 8'h07);
        req = '0;
        // randomized traffic with occasional lingering req, early drops and reset pulses
        prev_ack = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if ((ack[i] && $urandom_range(3) != 0) || prev_ack[i] || $urandom_range(63) == 0) req[i] = 1'b0;
                end else if ($urandom_range(9) < 3) begin
                    req[i] = 1'b1;
                    bin[4*i +: 4] = 4'($urandom_range(15));
                end
            end
            prev_ack = ack;
            if ($urandom_range(499) == 0) begin
                rst = 1'b0;
                #2;
                rst = 1'b1;
            end
        end
        req = '0;
        for (int c = 0; c < 10; c++) step();
        chk("drain_idle", {busy, ack}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin arbiter and sequencer that shares one registered 4-bit binary-to-BCD converter among `N_REQ` requesters, such as per-digit display channels and counter readouts.

- It grants one requester, drives the converter input, and waits out the converter's one-cycle register latency.
- It then returns the 8-bit BCD result with a one-cycle acknowledge to the granted requester.
- It sits between the requesting datapath blocks and the single shared converter instance, which runs on the same `clk`/`rst`.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of requester index; must equal clog2(`N_REQ`).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  `N_REQ`  per-requester conversion request, level; held until its `ack` bit pulses.
- `bin`  in  4*`N_REQ`  flattened binary operands; requester i uses bits [4i+3:4i], held stable while `req[i]` is high.
- `conv_bin`  out  4  operand to shared converter, registered.
- `conv_bcd`  in  8  converter result, {tens, ones}; valid one cycle after `conv_bin` is presented.
- `ack`  out  `N_REQ`  one-hot, one-cycle pulse marking completion for the served requester.
- `resp_bcd`  out  8  BCD result of the last completed conversion; held until the next completion.
- `resp_id`  out  `ID_W`  index of the last served requester; held with `resp_bcd`.
- `busy`  out  1  high whenever FSM is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - Compute eligible = `req` & ~`ack`. The requester acked this cycle is masked so a not-yet-dropped `req` cannot win again.
  - If eligible is nonzero, select the winner as the first set bit scanning upward from `ptr`, wrapping from `N_REQ`-1 to 0.
  - Register `grant_id` ← winner and `conv_bin` ← `bin[winner]`, then go to ISSUE.
  - If eligible is zero, stay in IDLE; `conv_bin` holds its value.
- ISSUE: the converter registers `conv_bin` at this edge. Go to CAPTURE. No `req` sampling.
- CAPTURE:
  - Register `resp_bcd` ← `conv_bcd` and `resp_id` ← `grant_id`.
  - Set `ack` ← one-hot(`grant_id`).
  - Set `ptr` ← `grant_id`+1, wrapping to 0 past `N_REQ`-1.
  - Go to IDLE.
- `ack` is high only during the IDLE cycle immediately after CAPTURE. It clears on the next edge.
- Round-robin: the most recently served requester has the lowest priority. Any continuously requesting requester is served within `N_REQ` grants.
- `req` changes while a requester is not granted take effect at the next IDLE sample. Changes to `bin[i]` after it has been sampled do not affect the in-flight conversion.
- The converter maps bin 0..15 to {tens, ones}, e.g. 13 → 8'h13. This block passes `conv_bcd` through unmodified.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant_id`=0, `conv_bin`=4'h0, `ack`=0, `resp_bcd`=8'h00, `resp_id`=0, `busy`=0.
- Latency: if `req[i]` is sampled high in IDLE at edge E0, `conv_bin` is valid after E0 and the converter captures it at E1. `resp_bcd`/`resp_id`/`ack[i]` are valid after E2, i.e. 3 cycles from request sample to ack.
- Throughput: one conversion per 3 cycles under continuous load, and the next grant is decided in the same cycle `ack` is high.
- Simultaneous requests: exactly one grant per IDLE sample; the others wait and are never dropped.
- Requester dropping `req` before its ack (while not granted): no conversion is issued. After it has been granted, the conversion completes and is acked regardless.
- Reset mid-operation (ISSUE or CAPTURE):
  - All registers return to their reset values immediately.
  - No `ack` is issued and the in-flight conversion is discarded.
  - Requesters still holding `req` are re-served after release, starting from `ptr`=0.
- `busy` is combinational from state. `ack`, `resp_bcd` and `resp_id` are registered.

## Test plan
- Reset: `rst` low with random `req`/`bin` → all outputs at reset values. After release with `req`=0 → `busy`=0 and no `ack` for 20 cycles.
- Single request: `req`=4'b0010, `bin[1]`=13 → `conv_bin`=13 one cycle later. `ack`=4'b0010 for one cycle, 3 cycles after the sample, with `resp_bcd`=8'h13 and `resp_id`=1.
- All four requesting from reset, `bin`={0,10,9,15} for i=3..0:
  - Acks in order 0,1,2,3, spaced 3 cycles apart.
  - `resp_bcd` sequence 8'h15, 8'h09, 8'h10, 8'h00.
  - Each requester drops `req` on its ack.
- Fairness: after requester 2 is served, `req`=4'b1001 → requester 3 is served before 0. Then requester 0 holds `req` and is served next.
- Ack masking: requester 1 keeps `req` high one cycle past its ack while requester 3 is also requesting → the next grant goes to 3, not 1.
- Reset mid-op: assert `rst` during ISSUE of a `bin`=7 request → no `ack`. After release with `req` held → `ack` with `resp_bcd`=8'h07 three cycles after the first IDLE sample.
